serial_subtractor: RTL

- Multi-cycle, digit-serial N-bit subtractor; computes diff = a - b - bin.
- Processes DIGIT bits per clock, LSB digit first, through a chain of DIGIT full-subtractor cells, with the borrow registered between digits.
- Extends the single-bit full subtractor to arbitrary width with a start/busy/done handshake.
- Sits in the arithmetic datapath where area matters more than single-cycle latency.

---
 rtl/serial_subtractor.sv | 95 +++++++++
 1 files changed

// File: rtl/serial_subtractor.sv
// serial_subtractor: digit-serial a - b - bin, DIGIT bits per clock, LSB digit first.
// Define SERIAL_SUBTRACTOR_OVF_EN to add the registered two's-complement overflow output ovf_o.
module serial_subtractor #(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             bin_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] diff_o,
`ifdef SERIAL_SUBTRACTOR_OVF_EN
  output logic             bout_o,
  output logic             ovf_o
`else
  output logic             bout_o
`endif
);
  localparam int NDIG = WIDTH / DIGIT;
  localparam int CW = NDIG > 1 ? $clog2(NDIG) : 1;
  if (WIDTH < 1 || DIGIT < 1 || DIGIT > WIDTH || WIDTH % DIGIT != 0) begin : g_bad_param
    $fatal(1, "serial_subtractor: DIGIT must be in 1..WIDTH and divide WIDTH");
  end
  typedef enum logic {IDLE, RUN} state_t;
  state_t state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, diff_q, diff_d, shifted;
  logic [CW-1:0] cnt_q, cnt_d;
  logic br_q, br_d, bout_q, bout_d, done_q;
  logic accept, run, last;
  logic [DIGIT:0] c;
  logic [DIGIT-1:0] dd;
  assign c[0] = br_q;
  for (genvar i = 0; i < DIGIT; i++) begin : g_cell
    assign dd[i]  = a_q[i] ^ b_q[i] ^ c[i];
    assign c[i+1] = (~a_q[i] & b_q[i]) | (~(a_q[i] ^ b_q[i]) & c[i]);
  end
  // Result digits fill the minuend register from the top as its digits are consumed.
  assign shifted = (a_q >> DIGIT) | (WIDTH'(dd) << (WIDTH - DIGIT));
  assign accept  = state_q == IDLE && start_i;
  assign run     = state_q == RUN;
  assign last    = run && cnt_q == CW'(NDIG - 1);
  always_comb begin
    state_d = accept ? RUN : last ? IDLE : state_q;
    a_d     = accept ? a_i : run ? shifted : a_q;
    b_d     = accept ? b_i : run ? b_q >> DIGIT : b_q;
    br_d    = accept ? bin_i : run ? c[DIGIT] : br_q;
    cnt_d   = accept ? '0 : run ? cnt_q + CW'(1) : cnt_q;
    diff_d  = last ? shifted : diff_q;
    bout_d  = last ? c[DIGIT] : bout_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      br_q    <= 1'b0;
      cnt_q   <= '0;
      diff_q  <= '0;
      bout_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      br_q    <= br_d;
      cnt_q   <= cnt_d;
      diff_q  <= diff_d;
      bout_q  <= bout_d;
      done_q  <= last;
    end
  end
  assign busy_o = run;
  assign done_o = done_q;
  assign diff_o = diff_q;
  assign bout_o = bout_q;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
  logic sa_q, sb_q, ovf_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sa_q  <= 1'b0;
      sb_q  <= 1'b0;
      ovf_q <= 1'b0;
    end else begin
      sa_q  <= accept ? a_i[WIDTH-1] : sa_q;
      sb_q  <= accept ? b_i[WIDTH-1] : sb_q;
      ovf_q <= last ? (sa_q != sb_q) && (shifted[WIDTH-1] != sa_q) : ovf_q;
    end
  end
  assign ovf_o = ovf_q;
`endif
endmodule
